// File: rtl/policy_table_loader_pkg.sv
// rtl/policy_table_loader_pkg.sv - shared constants for the AI policy table (game server AI)
package policy_table_loader_pkg;

    // 5 balls x 2 paddles, each a base-3 trit relative to the paddle
    localparam int PT_NUM_TRITS   = 10;
    localparam int PT_NUM_ENTRIES = 59049;
    localparam int PT_ADDR_W      = 16;

    localparam int unsigned PT_TRIT_WEIGHT [PT_NUM_TRITS] =
        '{1, 3, 9, 27, 81, 243, 729, 2187, 6561, 19683};

    typedef enum logic [1:0] {
        REL_IN_BAND = 2'd0,
        REL_ABOVE   = 2'd1,
        REL_BELOW   = 2'd2
    } rel_code_e;

    // RAM value + 1 is the action the AI paddle takes
    localparam logic [1:0] ACT_CODE_MIN  = 2'd0;
    localparam logic [1:0] ACT_CODE_MAX  = 2'd2;
    localparam logic [1:0] ACT_CODE_SAFE = 2'd0;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_WAIT_BYTE = 3'd1,
        ST_WRITE     = 3'd2,
        ST_WAIT_CSUM = 3'd3,
        ST_DONE      = 3'd4
    } state_e;

    function automatic logic entry_is_legal(input logic [1:0] entry);
        return entry <= ACT_CODE_MAX;
    endfunction

    function automatic logic [1:0] entry_sanitize(input logic [1:0] entry);
        return entry_is_legal(entry) ? entry : ACT_CODE_SAFE;
    endfunction

    function automatic int unsigned trit_index(input logic [2*PT_NUM_TRITS-1:0] trits);
        int unsigned idx;
        idx = 0;
        for (int i = 0; i < PT_NUM_TRITS; i++) begin
            idx = idx + 32'(trits[2*i +: 2]) * PT_TRIT_WEIGHT[i];
        end
        return idx;
    endfunction

endpackage

// File: rtl/policy_table_loader.sv
// rtl/policy_table_loader.sv - unpacks the host byte stream into 2-bit policy RAM writes
module policy_table_loader
    import policy_table_loader_pkg::*;
#(
    parameter int NUM_ENTRIES = PT_NUM_ENTRIES,
    parameter int ADDR_W      = PT_ADDR_W
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_start,
    input  logic              i_in_valid,
    input  logic [7:0]        i_in_data,
    output logic              o_in_ready,
    output logic              o_mem_we,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [1:0]        o_mem_din,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_err
);

    state_e            r_state;
    state_e            w_next_state;
    logic [ADDR_W-1:0] r_addr;
    logic [1:0]        r_k;
    logic [7:0]        r_byte;
    logic [7:0]        r_csum;
    logic              r_err;

    logic [1:0]        w_entry;
    logic              w_illegal;
    logic              w_last_addr;
    logic              w_start_load;
    logic              w_hs;

    assign w_entry      = r_byte[{r_k, 1'b0} +: 2];
    assign w_illegal    = !entry_is_legal(w_entry);
    assign w_last_addr  = (r_addr == ADDR_W'(NUM_ENTRIES - 1));
    assign w_start_load = i_start && (r_state == ST_IDLE || r_state == ST_DONE);
    assign w_hs         = i_in_valid && o_in_ready;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        o_in_ready   = 1'b0;
        o_mem_we     = 1'b0;
        o_busy       = 1'b0;
        o_done       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (i_start) w_next_state = ST_WAIT_BYTE;
            end
            ST_WAIT_BYTE: begin
                o_busy     = 1'b1;
                o_in_ready = 1'b1;
                if (i_in_valid) w_next_state = ST_WRITE;
            end
            ST_WRITE: begin
                o_busy   = 1'b1;
                o_mem_we = 1'b1;
                // The final address ends the data phase even mid-byte
                if (w_last_addr) begin
                    w_next_state = ST_WAIT_CSUM;
                end else if (r_k == 2'd3) begin
                    w_next_state = ST_WAIT_BYTE;
                end
            end
            ST_WAIT_CSUM: begin
                o_busy     = 1'b1;
                o_in_ready = 1'b1;
                if (i_in_valid) w_next_state = ST_DONE;
            end
            ST_DONE: begin
                o_done = 1'b1;
                if (i_start) w_next_state = ST_WAIT_BYTE;
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_addr <= '0;
            r_k    <= 2'd0;
            r_byte <= 8'd0;
            r_csum <= 8'd0;
            r_err  <= 1'b0;
        end else if (w_start_load) begin
            r_addr <= '0;
            r_csum <= 8'd0;
            r_err  <= 1'b0;
        end else begin
            case (r_state)
                ST_WAIT_BYTE: begin
                    if (w_hs) begin
                        r_byte <= i_in_data;
                        r_csum <= r_csum ^ i_in_data;
                        r_k    <= 2'd0;
                    end
                end
                ST_WRITE: begin
                    if (w_illegal) r_err <= 1'b1;
                    if (!w_last_addr) r_addr <= r_addr + ADDR_W'(1);
                    r_k <= r_k + 2'd1;
                end
                ST_WAIT_CSUM: begin
                    if (w_hs && (i_in_data != r_csum)) r_err <= 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

    // An illegal entry shows on err in the same cycle it is written
    assign o_err      = r_err || (r_state == ST_WRITE && w_illegal);
    assign o_mem_addr = r_addr;
    assign o_mem_din  = entry_sanitize(w_entry);

endmodule

// File: tb/tb_policy_table_loader.sv
// tb/tb_policy_table_loader.sv - directed and randomized bench for policy_table_loader
module tb_policy_table_loader;

    localparam int TB_N = 6;
    localparam int TB_AW = 16;

    logic             i_clk = 1'b0;
    logic             i_rst = 1'b1;
    logic             i_start = 1'b0;
    logic             i_in_valid = 1'b0;
    logic [7:0]       i_in_data = 8'd0;
    logic             o_in_ready;
    logic             o_mem_we;
    logic [TB_AW-1:0] o_mem_addr;
    logic [1:0]       o_mem_din;
    logic             o_busy;
    logic             o_done;
    logic             o_err;

    int n_assert = 0;
    int n_fail   = 0;
    int cyc      = 0;

    logic [7:0]       data_q[$];
    logic [TB_AW-1:0] w_addr_q[$];
    logic [1:0]       w_din_q[$];
    logic             w_err_q[$];
    int               hs_q[$];

    policy_table_loader #(.NUM_ENTRIES(TB_N), .ADDR_W(TB_AW)) dut (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_start    (i_start),
        .i_in_valid (i_in_valid),
        .i_in_data  (i_in_data),
        .o_in_ready (o_in_ready),
        .o_mem_we   (o_mem_we),
        .o_mem_addr (o_mem_addr),
        .o_mem_din  (o_mem_din),
        .o_busy     (o_busy),
        .o_done     (o_done),
        .o_err      (o_err)
    );

    always #5 i_clk = ~i_clk;

    always @(posedge i_clk) cyc = cyc + 1;

    always @(negedge i_clk) begin
        if (o_mem_we) begin
            w_addr_q.push_back(o_mem_addr);
            w_din_q.push_back(o_mem_din);
            w_err_q.push_back(o_err);
        end
        if (i_in_valid && o_in_ready) hs_q.push_back(cyc);
    end

    initial begin
        #500000;
        $display("FAIL watchdog: observed no completion, expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap, input bit stray);
        int   budget;
        logic hs;
        for (int g = 0; g < gap; g++) begin
            i_in_valid = 1'b0;
            tick();
        end
        i_in_valid = 1'b1;
        i_in_data  = b;
        budget     = 0;
        hs         = 1'b0;
        while (!hs && budget < 50) begin
            hs = o_in_ready;
            if (stray) i_start = (budget % 2 == 1);
            tick();
            budget++;
        end
        i_start = 1'b0;
        chk("handshake", {31'd0, hs}, 32'd1);
    endtask

    // Expected results come straight from the stream rules: entry i is pair i%4 of byte i/4
    task automatic check_load(input logic [7:0] csum_b);
        logic       exp_err;
        logic [1:0] e;
        logic [7:0] x;
        chk("write_count", w_addr_q.size(), TB_N);
        exp_err = 1'b0;
        for (int i = 0; i < TB_N && i < w_addr_q.size(); i++) begin
            e = 2'(data_q[i/4] >> (2 * (i % 4)));
            if (e == 2'd3) exp_err = 1'b1;
            chk("write_addr", w_addr_q[i], i);
            chk("write_data", w_din_q[i], (e == 2'd3) ? 32'd0 : 32'(e));
            chk("write_err", w_err_q[i], exp_err);
        end
        x = 8'd0;
        foreach (data_q[j]) x = x ^ data_q[j];
        if (x != csum_b) exp_err = 1'b1;
        chk("end_done", o_done, 1);
        chk("end_busy", o_busy, 0);
        chk("end_err", o_err, exp_err);
        chk("end_ready", o_in_ready, 0);
        chk("end_we", o_mem_we, 0);
    endtask

    task automatic do_load(input logic [7:0] csum_b, input int gapmax, input bit stray);
        int budget;
        w_addr_q.delete();
        w_din_q.delete();
        w_err_q.delete();
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
        hs_q.delete();
        chk("start_busy", o_busy, 1);
        chk("start_ready", o_in_ready, 1);
        chk("start_done", o_done, 0);
        chk("start_err", o_err, 0);
        foreach (data_q[j]) send_byte(data_q[j], $urandom_range(0, gapmax), stray);
        send_byte(csum_b, $urandom_range(0, gapmax), stray);
        i_in_valid = 1'b0;
        budget = 0;
        while (!o_done && budget < 100) begin
            tick();
            budget++;
        end
        check_load(csum_b);
    endtask

    function automatic logic [7:0] xor_all();
        logic [7:0] x;
        x = 8'd0;
        foreach (data_q[j]) x = x ^ data_q[j];
        return x;
    endfunction

    initial begin
        logic [7:0] b;
        logic [7:0] cs;
        int         r;
        int         n_ent;

        // reset state
        repeat (3) tick();
        chk("rst_busy", o_busy, 0);
        chk("rst_done", o_done, 0);
        chk("rst_err", o_err, 0);
        chk("rst_we", o_mem_we, 0);
        chk("rst_ready", o_in_ready, 0);
        chk("rst_addr", o_mem_addr, 0);
        chk("rst_din", o_mem_din, 0);
        i_rst = 1'b0;
        tick();

        // normal load
        data_q = '{8'h24, 8'h06};
        do_load(8'h22, 0, 1'b0);

        // illegal entries, then checksum mismatch
        data_q = '{8'hFF, 8'h00};
        do_load(8'hFF, 1, 1'b0);
        data_q = '{8'h24, 8'h06};
        do_load(8'h23, 0, 1'b0);

        // backpressure with stray start pulses while busy
        data_q = '{8'($urandom_range(0, 255)) & 8'h66, 8'($urandom_range(0, 255)) & 8'h66};
        do_load(xor_all(), 0, 1'b1);
        chk("hs_count", hs_q.size(), 3);
        for (int j = 0; j < 2 && j + 1 < hs_q.size(); j++) begin
            n_ent = (TB_N - 4 * j) < 4 ? (TB_N - 4 * j) : 4;
            chk("hs_interval", hs_q[j+1] - hs_q[j], 1 + n_ent);
        end

        // mid-load reset after two writes
        w_addr_q.delete();
        w_din_q.delete();
        w_err_q.delete();
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
        send_byte(8'h24, 0, 1'b0);
        i_in_valid = 1'b0;
        tick();
        i_rst = 1'b1;
        tick();
        chk("mrst_we", o_mem_we, 0);
        chk("mrst_busy", o_busy, 0);
        chk("mrst_done", o_done, 0);
        chk("mrst_err", o_err, 0);
        chk("mrst_ready", o_in_ready, 0);
        chk("mrst_addr", o_mem_addr, 0);
        i_rst = 1'b0;
        repeat (8) tick();
        chk("mrst_writes", w_addr_q.size(), 2);
        if (w_din_q.size() >= 2) chk("mrst_din1", w_din_q[1], 1);
        data_q = '{8'h24, 8'h06};
        do_load(8'h22, 0, 1'b0);

        // randomized loads, including ignored junk in the unused pairs of the last byte
        for (int t = 0; t < 8; t++) begin
            data_q.delete();
            for (int j = 0; j < 2; j++) begin
                b = 8'd0;
                for (int p = 0; p < 4; p++) begin
                    r = $urandom_range(0, 9);
                    b[2*p +: 2] = (r == 0) ? 2'd3 : 2'(r % 3);
                end
                data_q.push_back(b);
            end
            cs = xor_all();
            if ($urandom_range(0, 3) == 0) cs = cs ^ 8'($urandom_range(1, 255));
            do_load(cs, 3, 1'($urandom_range(0, 1)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/policy_table_loader.md
Name: policy_table_loader

Overview:
- Write side of the AI policy table, the 2-bit-wide block RAM that the AI player reads. Index = base-3 encoding of 5 balls × 2 paddles, 3^10 = 59049 entries.
- Receives a packed byte stream from the host link and writes one 2-bit entry per cycle into the RAM write port.
- Checks each entry for legality and the stream against a trailing XOR checksum.
- Drives busy so the game server holds the AI paddles while the table is being rewritten.

Parameters:
- NUM_ENTRIES, 59049, number of table entries written per load.
- ADDR_W, 16, RAM address width; NUM_ENTRIES must be ≤ 2^ADDR_W.

Ports:
- clk  in  1  system clock
- rst  in  1  reset, synchronous, active-high
- start  in  1  single-cycle pulse; begins a load
- in_valid  in  1  in_data valid
- in_data  in  8  packed byte: entry k in bits [2k+1:2k], k = 0..3, LSB pair first
- in_ready  out  1  loader accepts a byte this cycle
- mem_we  out  1  RAM write enable
- mem_addr  out  ADDR_W  RAM write address
- mem_din  out  2  RAM write data
- busy  out  1  load in progress
- done  out  1  load finished; level signal
- err  out  1  sticky: illegal entry or checksum mismatch

Behaviour:
- Reset values: all outputs 0; state IDLE; address counter 0; checksum accumulator 0.
- Reset is synchronous and overrides everything, including a load in progress. After a mid-load reset the table is partially written, done=0, and no further writes occur.
- States: IDLE, WAIT_BYTE, WRITE, WAIT_CSUM, DONE.
- IDLE or DONE, start=1:
  - Clear err, address counter and checksum.
  - Next state WAIT_BYTE; busy=1, done=0.
- start in WAIT_BYTE, WRITE or WAIT_CSUM is ignored.
- WAIT_BYTE:
  - in_ready=1.
  - On in_valid & in_ready in cycle N: latch the byte, XOR it into the checksum, set entry index k=0, go to WRITE.
- WRITE, cycles N+1 onward, one entry per cycle:
  - mem_we=1, mem_addr=address counter, mem_din=entry k.
  - Address counter +1 and k +1 every cycle.
  - in_ready=0; in_valid is ignored and no data is lost.
- Leaving WRITE:
  - After k=3: go to WAIT_BYTE (in_ready=1 at N+5). Throughput is 1 byte per 5 cycles.
  - After writing address NUM_ENTRIES-1: go to WAIT_CSUM immediately, even if k<3. The unused pairs of that byte are ignored but still included in the checksum (the whole byte is XORed).
- Illegal entry (value 3): write 0 instead and set err=1. err stays set until the next start.
- WAIT_CSUM:
  - in_ready=1.
  - On handshake: if in_data ≠ accumulated XOR, set err=1.
  - Go to DONE: busy=0, done=1.
- DONE: done and err hold until start or rst.
- mem_we is 0 in every state except WRITE. mem_addr and mem_din are don't-care when mem_we=0, but are held stable.
- Bytes needed: ceil(NUM_ENTRIES/4) data bytes plus 1 checksum byte. Default: 14763 + 1; the last data byte carries 1 valid entry.
- The address counter never exceeds NUM_ENTRIES-1, so there is no wrap-around.

Decomposition:
- Shared package (game server AI): NUM_ENTRIES, the trit weights 1, 3, 9 … 19683, the paddle-relative codes (0 in-band, 1 above, 2 below), and the legal action codes 0..2 (RAM value + 1 = action).
- Single module; no sub-module warranted.

Test Plan:
- Reset check: assert rst → all outputs 0, in_ready=0. Pulse start → busy=1, in_ready=1 the next cycle.
- Normal load, NUM_ENTRIES=6: stream 0x24, 0x06, checksum 0x22.
  - Writes (addr, data): (0,0) (1,1) (2,2) (3,0) (4,2) (5,1).
  - mem_we high exactly 6 cycles; then done=1, err=0, busy=0.
- Illegal entry, NUM_ENTRIES=6: stream 0xFF, 0x00, checksum 0xFF.
  - addr 0–3 written with 0; err=1 from the first WRITE cycle.
  - Ends with done=1, err=1.
- Checksum mismatch: same stream as the normal load but checksum 0x23 → all 6 writes correct; done=1, err=1.
- Backpressure: hold in_valid=1 continuously with the next byte → exactly one handshake per 5 cycles; bytes are not double-consumed or skipped. start pulses while busy are ignored: address does not reset.
- Mid-load reset: assert rst after 2 writes → next cycle all outputs 0 and no further mem_we. A new start reloads from address 0 and completes correctly.
